// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
//   Instruction-memory read handshake between the fetch stage and memory.
//   The fetch side issues a one-cycle read strobe with a word address; memory
//   answers later with a single-cycle data-valid pulse.
//
//   Signals
//     oMemAddr   32  fetch address (driven by fetch side)
//     oMemRd      1  one-cycle read request strobe (driven by fetch side)
//     iMemData   32  read data (driven by memory)
//     iMemValid   1  read data valid, single-cycle pulse (driven by memory)
//
//   Modports
//     master : fetch unit side
//     slave  : memory side
// ---------------------------------------------------------------------------
interface fetch_unit_if;
  logic [31:0] oMemAddr;
  logic        oMemRd;
  logic [31:0] iMemData;
  logic        iMemValid;

  modport master (
    output oMemAddr,
    output oMemRd,
    input  iMemData,
    input  iMemValid
  );

  modport slave (
    input  oMemAddr,
    input  oMemRd,
    output iMemData,
    output iMemValid
  );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage feeding the decoder. Holds the PC, fetches one
//   word per instruction over the memory handshake and latches it into the
//   instruction register. The IR stays stable until iNext. Branches/jumps
//   redirect the PC through iPCLoad/iPCNew at any point of the fetch.
//
//   Parameters
//     RESET_PC     PC value loaded on reset
//     PC_INC       PC increment per instruction (word-addressed memory)
//     TIMEOUT_CYC  WAIT cycles allowed before a fetch fault
//
//   Optional feature (macro FETCH_TIMEOUT_EN)
//     Defined   : a WAIT-cycle counter raises oFault and parks the FSM in
//                 FAULT when memory does not answer within TIMEOUT_CYC cycles.
//     Undefined : no counter, no FAULT state, oFault tied 0.
//
//   Ports
//     iClk       in   1   clock, rising edge
//     nRst       in   1   asynchronous active-low reset
//     iStall     in   1   blocks a new memory request (FETCH only)
//     iNext      in   1   decoder consumed oINS, start next fetch
//     iPCLoad    in   1   redirect PC
//     iPCNew     in   32  redirect target
//     mem        if       memory handshake (master side)
//     oINS       out  32  instruction register
//     oINSValid  out  1   oINS holds a valid, unconsumed instruction
//     oPC        out  32  current PC
//     oFault     out  1   fetch timeout fault
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] PC_INC      = 32'd1,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic               iClk,
  input  logic               nRst,
  input  logic               iStall,
  input  logic               iNext,
  input  logic               iPCLoad,
  input  logic [31:0]        iPCNew,
  fetch_unit_if.master       mem,
  output logic [31:0]        oINS,
  output logic               oINSValid,
  output logic [31:0]        oPC,
  output logic               oFault
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1) + 1;

  // A zero timeout would fault before memory could ever answer.
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("fetch_unit: TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_mem_addr;
  logic        r_mem_rd;
  logic [31:0] r_ins;
  logic        r_ins_vld;
  // Set when a redirect arrives while a read is outstanding: the returning
  // word belongs to the old path and must be dropped.
  logic        r_pend;
`ifdef FETCH_TIMEOUT_EN
  logic [TMO_W-1:0] r_tmo;
  logic             r_fault;
`endif

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_mem_addr <= 32'h0000_0000;
      r_mem_rd   <= 1'b0;
      r_ins      <= 32'h0000_0000;
      r_ins_vld  <= 1'b0;
      r_pend     <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      r_tmo      <= '0;
      r_fault    <= 1'b0;
`endif
    end else begin
      // Read strobe is a single-cycle pulse unless FETCH re-asserts it.
      r_mem_rd <= 1'b0;
      case (r_state)
        S_FETCH: begin
          if (iPCLoad) begin
            r_pc <= iPCNew;
          end else if (!iStall) begin
            r_mem_addr <= r_pc;
            r_mem_rd   <= 1'b1;
            r_state    <= S_WAIT;
`ifdef FETCH_TIMEOUT_EN
            r_tmo      <= '0;
`endif
          end
        end

        S_WAIT: begin
          if (mem.iMemValid) begin
            if (r_pend || iPCLoad) begin
              // Stale word: drop it and refetch from the redirected PC.
              r_pend  <= 1'b0;
              r_state <= S_FETCH;
              if (iPCLoad) begin
                r_pc <= iPCNew;
              end
            end else begin
              r_ins     <= mem.iMemData;
              r_ins_vld <= 1'b1;
              r_pc      <= r_pc + PC_INC;
              r_state   <= S_HOLD;
            end
          end else begin
            if (iPCLoad) begin
              r_pend <= 1'b1;
              r_pc   <= iPCNew;
            end
`ifdef FETCH_TIMEOUT_EN
            if (r_tmo == TMO_W'(TIMEOUT_CYC - 1)) begin
              r_fault <= 1'b1;
              r_state <= S_FAULT;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
`endif
          end
        end

        S_HOLD: begin
          // A redirect always wins over the sequential PC, with or without iNext.
          if (iPCLoad) begin
            r_pc <= iPCNew;
          end
          if (iNext) begin
            r_ins_vld <= 1'b0;
            r_state   <= S_FETCH;
          end
        end

        default: begin
          // FAULT: parked until reset.
          r_ins_vld <= 1'b0;
        end
      endcase
    end
  end

  assign mem.oMemAddr = r_mem_addr;
  assign mem.oMemRd   = r_mem_rd;
  assign oINS         = r_ins;
  assign oINSValid    = r_ins_vld;
  assign oPC          = r_pc;
`ifdef FETCH_TIMEOUT_EN
  assign oFault       = r_fault;
`else
  assign oFault       = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        iClk;
  logic        nRst;
  logic        iStall;
  logic        iNext;
  logic        iPCLoad;
  logic [31:0] iPCNew;
  logic [31:0] oINS;
  logic        oINSValid;
  logic [31:0] oPC;
  logic        oFault;

  fetch_unit_if u_mem_if ();

  fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .PC_INC      (32'd1),
    .TIMEOUT_CYC (4)
  ) u_dut (
    .iClk      (iClk),
    .nRst      (nRst),
    .iStall    (iStall),
    .iNext     (iNext),
    .iPCLoad   (iPCLoad),
    .iPCNew    (iPCNew),
    .mem       (u_mem_if.master),
    .oINS      (oINS),
    .oINSValid (oINSValid),
    .oPC       (oPC),
    .oFault    (oFault)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int vec_cnt = 0;
  int err_cnt = 0;
  int rd_long = 0;
  int mem_lat = 1;
  int mem_en  = 0;
  int spur_req = 0;

  // Memory contents: word @0 is the reference pattern, the rest are tagged by address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0) return 32'h1234_5678;
    return 32'hC0DE_0000 + a;
  endfunction

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory model: answers a read mem_lat cycles after the strobe (0 = same cycle).
  initial begin
    int cnt;
    int spur_seen;
    logic [31:0] a;
    cnt = -1;
    spur_seen = 0;
    a = '0;
    u_mem_if.iMemValid = 1'b0;
    u_mem_if.iMemData  = '0;
    forever begin
      @(posedge iClk);
      #1;
      u_mem_if.iMemValid = 1'b0;
      if (cnt == 0) begin
        u_mem_if.iMemValid = 1'b1;
        u_mem_if.iMemData  = memf(a);
        cnt = -1;
      end else if (cnt > 0) begin
        cnt--;
      end
      if (spur_req != spur_seen) begin
        spur_seen = spur_req;
        u_mem_if.iMemValid = 1'b1;
        u_mem_if.iMemData  = 32'hDEAD_BEEF;
      end
      if (u_mem_if.oMemRd && mem_en != 0) begin
        a = u_mem_if.oMemAddr;
        if (mem_lat == 0) begin
          u_mem_if.iMemValid = 1'b1;
          u_mem_if.iMemData  = memf(a);
        end else begin
          cnt = mem_lat - 1;
        end
      end
    end
  end

  // Read strobe width monitor.
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge iClk);
      if (prev && u_mem_if.oMemRd) rd_long++;
      prev = u_mem_if.oMemRd;
    end
  end

  task automatic wait_ins(output int n);
    n = 0;
    do begin
      @(negedge iClk);
      n++;
    end while (!oINSValid && n < 30);
  endtask

  task automatic next_and_wait(output int n);
    iNext = 1'b1;
    @(negedge iClk);
    iNext = 1'b0;
    n = 1;
    while (!oINSValid && n < 30) begin
      @(negedge iClk);
      n++;
    end
  endtask

  task automatic wait_rd(output int n);
    n = 0;
    do begin
      @(negedge iClk);
      n++;
    end while (!u_mem_if.oMemRd && n < 20);
  endtask

  initial begin
    int n;
    int rd_seen;
    logic [31:0] exp_a;
    nRst    = 1'b0;
    iStall  = 1'b0;
    iNext   = 1'b0;
    iPCLoad = 1'b0;
    iPCNew  = '0;

    // Reset state
    repeat (2) @(negedge iClk);
    check_vec("rst_ins_vld", {31'd0, oINSValid}, 32'd0);
    check_vec("rst_mem_rd",  {31'd0, u_mem_if.oMemRd}, 32'd0);
    check_vec("rst_addr",    u_mem_if.oMemAddr, 32'h0);
    check_vec("rst_ins",     oINS, 32'h0);
    check_vec("rst_pc",      oPC, 32'h0);
    check_vec("rst_fault",   {31'd0, oFault}, 32'd0);

    // First fetch, memory answers one cycle after the strobe
    mem_lat = 1;
    mem_en  = 1;
    nRst    = 1'b1;
    wait_ins(n);
    check_vec("t1_vld",  {31'd0, oINSValid}, 32'd1);
    check_vec("t1_addr", u_mem_if.oMemAddr, 32'h0);
    check_vec("t1_ins",  oINS, 32'h1234_5678);
    check_vec("t1_pc",   oPC, 32'h1);
    repeat (3) @(negedge iClk);
    check_vec("t1_hold_ins", oINS, 32'h1234_5678);
    check_vec("t1_hold_vld", {31'd0, oINSValid}, 32'd1);
    check_vec("t1_hold_pc",  oPC, 32'h1);

    // Back-to-back fetches with zero-wait memory
    mem_lat = 0;
    for (int i = 0; i < 3; i++) begin
      exp_a = 32'(i + 1);
      next_and_wait(n);
      check_vec($sformatf("t2_lat%0d", i), 32'(n), 32'd3);
      check_vec($sformatf("t2_addr%0d", i), u_mem_if.oMemAddr, exp_a);
      check_vec($sformatf("t2_ins%0d", i), oINS, memf(exp_a));
      check_vec($sformatf("t2_pc%0d", i), oPC, exp_a + 32'd1);
    end

    // Redirect while a read is outstanding
    mem_lat = 2;
    iNext = 1'b1;
    @(negedge iClk);
    iNext = 1'b0;
    wait_rd(n);
    iPCLoad = 1'b1;
    iPCNew  = 32'h40;
    @(negedge iClk);
    iPCLoad = 1'b0;
    check_vec("t3_no_vld", {31'd0, oINSValid}, 32'd0);
    wait_ins(n);
    check_vec("t3_addr", u_mem_if.oMemAddr, 32'h40);
    check_vec("t3_ins",  oINS, memf(32'h40));
    check_vec("t3_pc",   oPC, 32'h41);

    // iNext together with iPCLoad in HOLD
    mem_lat = 0;
    iNext   = 1'b1;
    iPCLoad = 1'b1;
    iPCNew  = 32'h10;
    @(negedge iClk);
    iNext   = 1'b0;
    iPCLoad = 1'b0;
    check_vec("t4_drop", {31'd0, oINSValid}, 32'd0);
    wait_ins(n);
    check_vec("t4_addr", u_mem_if.oMemAddr, 32'h10);
    check_vec("t4_ins",  oINS, memf(32'h10));
    check_vec("t4_pc",   oPC, 32'h11);

    // iPCLoad alone in HOLD keeps the instruction valid
    iPCLoad = 1'b1;
    iPCNew  = 32'hFFFF_FFFF;
    @(negedge iClk);
    iPCLoad = 1'b0;
    check_vec("t4b_vld", {31'd0, oINSValid}, 32'd1);
    check_vec("t4b_ins", oINS, memf(32'h10));
    check_vec("t4b_pc",  oPC, 32'hFFFF_FFFF);

    // PC wrap at the top of the address space
    next_and_wait(n);
    check_vec("t5_addr", u_mem_if.oMemAddr, 32'hFFFF_FFFF);
    check_vec("t5_ins",  oINS, memf(32'hFFFF_FFFF));
    check_vec("t5_wrap", oPC, 32'h0);

    // Stray data-valid in HOLD is ignored
    spur_req++;
    repeat (2) @(negedge iClk);
    check_vec("spur_ins", oINS, memf(32'hFFFF_FFFF));
    check_vec("spur_vld", {31'd0, oINSValid}, 32'd1);
    check_vec("spur_pc",  oPC, 32'h0);

    // Stall in FETCH, with a redirect taken while stalled
    iStall = 1'b1;
    iNext  = 1'b1;
    @(negedge iClk);
    iNext   = 1'b0;
    iPCLoad = 1'b1;
    iPCNew  = 32'h20;
    @(negedge iClk);
    iPCLoad = 1'b0;
    rd_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge iClk);
      if (u_mem_if.oMemRd) rd_seen++;
    end
    check_vec("t5_stall_rd", 32'(rd_seen), 32'd0);
    check_vec("t5_stall_pc", oPC, 32'h20);
    iStall = 1'b0;
    wait_ins(n);
    check_vec("t5_addr2", u_mem_if.oMemAddr, 32'h20);
    check_vec("t5_ins2",  oINS, memf(32'h20));
    check_vec("t5_pc2",   oPC, 32'h21);

`ifdef FETCH_TIMEOUT_EN
    // Fetch timeout with silent memory
    mem_en = 0;
    iNext  = 1'b1;
    @(negedge iClk);
    iNext = 1'b0;
    wait_rd(n);
    repeat (3) @(negedge iClk);
    check_vec("t6_early", {31'd0, oFault}, 32'd0);
    @(negedge iClk);
    check_vec("t6_fault", {31'd0, oFault}, 32'd1);
    repeat (5) @(negedge iClk);
    check_vec("t6_sticky", {31'd0, oFault}, 32'd1);
    check_vec("t6_rd",     {31'd0, u_mem_if.oMemRd}, 32'd0);
    check_vec("t6_vld",    {31'd0, oINSValid}, 32'd0);
    nRst = 1'b0;
    @(negedge iClk);
    check_vec("t6_clear", {31'd0, oFault}, 32'd0);
    nRst = 1'b1;
`else
    check_vec("no_fault", {31'd0, oFault}, 32'd0);
`endif

    check_vec("rd_width", 32'(rd_long), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  // Absolute guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no end, expected finish");
    $fatal(1);
  end

endmodule
